wb_openram_arbiter: RTL

- Multi-master successor to the two-port Wishbone/OpenRAM wrapper.
- NUM_PORTS Wishbone classic slaves share one OpenRAM macro with an RW port 0 and a read-only port 1, all in a single clock domain.
- Port 0 is granted each cycle round-robin among all pending requests; port 1 concurrently serves a second pending read.
- Per-port write permission is set by parameter; a forbidden write terminates with err instead of ack.

---
 rtl/wb_openram_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/wb_openram_arbiter.sv
// wb_openram_arbiter: round-robin sharing of a dual-port OpenRAM (RW port 0, R port 1) among Wishbone slaves
module wb_openram_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_WIDTH = 8,
    parameter logic [NUM_PORTS-1:0] WRITABLE_MASK = {NUM_PORTS{1'b1}}
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic [NUM_PORTS-1:0]             wbs_stb_i,
    input  logic [NUM_PORTS-1:0]             wbs_cyc_i,
    input  logic [NUM_PORTS-1:0]             wbs_we_i,
    input  logic [4*NUM_PORTS-1:0]           wbs_sel_i,
    input  logic [32*NUM_PORTS-1:0]          wbs_dat_i,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  wbs_adr_i,
    output logic [NUM_PORTS-1:0]             wbs_ack_o,
    output logic [NUM_PORTS-1:0]             wbs_err_o,
    output logic [32*NUM_PORTS-1:0]          wbs_dat_o,
    output logic                             ram_clk0,
    output logic                             ram_csb0,
    output logic                             ram_web0,
    output logic [3:0]                       ram_wmask0,
    output logic [ADDR_WIDTH-1:0]            ram_addr0,
    output logic [31:0]                      ram_din0,
    input  logic [31:0]                      ram_dout0,
    output logic                             ram_clk1,
    output logic                             ram_csb1,
    output logic [ADDR_WIDTH-1:0]            ram_addr1,
    input  logic [31:0]                      ram_dout1
);
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    typedef enum logic {IDLE, ISSUED} state_t;
    state_t state [NUM_PORTS];
    logic [NUM_PORTS-1:0] pend, forb, gnt0, gnt1, err_q, used1;
    logic [PW-1:0] ptr0, ptr1, win0, win1;
    logic hit0, hit1;
    logic [ADDR_WIDTH-1:0] adr [NUM_PORTS];
    logic [31:0] dat [NUM_PORTS];
    logic [3:0] sel [NUM_PORTS];

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NUM_PORTS);
    endfunction

    always_comb begin
        pend = '0;
        forb = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            adr[i] = wbs_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            dat[i] = wbs_dat_i[i*32 +: 32];
            sel[i] = wbs_sel_i[i*4 +: 4];
            pend[i] = wb_rst_i & wbs_stb_i[i] & wbs_cyc_i[i] & (state[i] == IDLE);
            forb[i] = wbs_we_i[i] & ~WRITABLE_MASK[i];
        end
    end

    always_comb begin
        hit0 = 1'b0;
        win0 = '0;
        hit1 = 1'b0;
        win1 = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--)
            if (pend[wrap(int'(ptr0) + k)] & ~forb[wrap(int'(ptr0) + k)]) begin
                hit0 = 1'b1;
                win0 = wrap(int'(ptr0) + k);
            end
        for (int k = NUM_PORTS - 1; k >= 0; k--)
            if (pend[wrap(int'(ptr1) + k)] & ~wbs_we_i[wrap(int'(ptr1) + k)] & ~(hit0 && win0 == wrap(int'(ptr1) + k))) begin
                hit1 = 1'b1;
                win1 = wrap(int'(ptr1) + k);
            end
        gnt0 = '0;
        gnt1 = '0;
        gnt0[win0] = hit0;
        gnt1[win1] = hit1;
    end

    assign ram_clk0   = wb_clk_i;
    assign ram_clk1   = wb_clk_i;
    assign ram_csb0   = ~hit0;
    assign ram_web0   = ~(hit0 & wbs_we_i[win0]);
    assign ram_wmask0 = (hit0 & wbs_we_i[win0]) ? sel[win0] : 4'h0;
    assign ram_addr0  = hit0 ? adr[win0] : '0;
    assign ram_din0   = hit0 ? dat[win0] : 32'h0;
    assign ram_csb1   = ~hit1;
    assign ram_addr1  = hit1 ? adr[win1] : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < NUM_PORTS; i++) state[i] <= IDLE;
            err_q <= '0;
            used1 <= '0;
            ptr0  <= '0;
            ptr1  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                state[i] <= (gnt0[i] | gnt1[i] | (pend[i] & forb[i])) ? ISSUED : IDLE;
            err_q <= pend & forb;
            used1 <= gnt1;
            if (hit0) ptr0 <= wrap(int'(win0) + 1);
            if (hit1) ptr1 <= wrap(int'(win1) + 1);
        end
    end

    // a master dropping cyc during the issued cycle aborts; the response is swallowed
    always_comb begin
        wbs_ack_o = '0;
        wbs_err_o = '0;
        wbs_dat_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            wbs_ack_o[i] = (state[i] == ISSUED) & ~err_q[i] & wbs_cyc_i[i];
            wbs_err_o[i] = err_q[i] & wbs_cyc_i[i];
            wbs_dat_o[i*32 +: 32] = wbs_ack_o[i] ? (used1[i] ? ram_dout1 : ram_dout0) : 32'h0;
        end
    end
endmodule
